// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//   Slave-mode I2S deserializer. Recovers signed, left-aligned left/right audio
//   words from an external bit clock / word select / serial data stream and
//   presents them in the clk domain with a one-cycle valid strobe.
//
// Parameters
//   NUM_BITS    width of each recovered word
//   SLOT_BITS   s_clk cycles per channel slot (>= NUM_BITS)
//   SYNC_STAGES synchronizer depth for s_clk / word_select / serial_in (>= 2)
//
// Ports
//   clk         system clock (>= 4x s_clk)
//   rst         asynchronous active-low reset
//   s_clk       I2S bit clock (asynchronous to clk)
//   word_select I2S WS, 0 = left, 1 = right
//   serial_in   I2S serial data, MSB first
//   left_word   last completed left sample
//   right_word  last completed right sample
//   word_valid  one-cycle strobe: a word has just been updated
//   word_chan   channel of the word flagged by word_valid
//   frame_err   one-cycle strobe on slot length mismatch / missing WS edge
//   locked      high while aligned to the frame
// -----------------------------------------------------------------------------
module i2s_receiver #(
  parameter int NUM_BITS    = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_clk,
  input  logic                word_select,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] left_word,
  output logic [NUM_BITS-1:0] right_word,
  output logic                word_valid,
  output logic                word_chan,
  output logic                frame_err,
  output logic                locked
);

  localparam int CW = $clog2(SLOT_BITS + 2);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_BITS);
  localparam logic [CW-1:0] SAT_C  = CW'(SLOT_BITS + 1);
  localparam logic [CW-1:0] NB_C   = CW'(NUM_BITS);

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_ALIGN,
    ST_LOCKED
  } state_e;

  // Synchronizers and edge detect
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ws_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, ws_s, sd_s, sclk_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ws_s      = ws_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Framing state
  state_e                state_q, state_d;
  logic                  ws_prev_q, ws_prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_BITS-1:0]   shift_q, shift_d;
  logic [NUM_BITS-1:0]   cap_q, cap_d;
  logic                  commit_q, commit_d;
  logic                  commit_chan_q, commit_chan_d;

  // Output registers
  logic [NUM_BITS-1:0]   left_q, left_d;
  logic [NUM_BITS-1:0]   right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  chan_q, chan_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;

  // Helpers
  logic [CW-1:0]         cnt_inc;
  logic [NUM_BITS-1:0]   shifted;
  logic                  bit_in;
  logic                  ws_edge;

  assign cnt_inc = (cnt_q == SAT_C) ? cnt_q : cnt_q + 1'b1;
  assign shifted = {shift_q[NUM_BITS-2:0], sd_s};
  assign bit_in  = (cnt_inc <= NB_C);
  assign ws_edge = (ws_s != ws_prev_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q   <= '0;
      ws_sync_q     <= '0;
      sd_sync_q     <= '0;
      sclk_prev_q   <= 1'b0;
      ws_prev_q     <= 1'b0;
      cnt_q         <= '0;
      shift_q       <= '0;
      cap_q         <= '0;
      commit_q      <= 1'b0;
      commit_chan_q <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      valid_q       <= 1'b0;
      chan_q        <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
      ws_sync_q     <= {ws_sync_q[SYNC_STAGES-2:0], word_select};
      sd_sync_q     <= {sd_sync_q[SYNC_STAGES-2:0], serial_in};
      sclk_prev_q   <= sclk_s;
      ws_prev_q     <= ws_prev_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      cap_q         <= cap_d;
      commit_q      <= commit_d;
      commit_chan_q <= commit_chan_d;
      left_q        <= left_d;
      right_q       <= right_d;
      valid_q       <= valid_d;
      chan_q        <= chan_d;
      err_q         <= err_d;
      locked_q      <= locked_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ws_prev_d     = ws_prev_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    cap_d         = cap_q;
    commit_d      = 1'b0;
    commit_chan_d = commit_chan_q;
    left_d        = left_q;
    right_d       = right_q;
    valid_d       = 1'b0;
    chan_d        = chan_q;
    err_d         = 1'b0;
    locked_d      = locked_q;

    // Second pipeline stage: the word captured at the slot boundary is
    // published one cycle later, together with its strobe.
    if (commit_q) begin
      valid_d  = 1'b1;
      chan_d   = commit_chan_q;
      locked_d = 1'b1;
      if (commit_chan_q) begin
        right_d = cap_q;
      end else begin
        left_d = cap_q;
      end
    end

    if (sclk_rise) begin
      ws_prev_d = ws_s;
      case (state_q)
        ST_SEEK: begin
          // The boundary sample of a partial slot only establishes alignment.
          if (ws_edge) begin
            state_d = ST_ALIGN;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        default: begin
          if (ws_edge) begin
            // Boundary sample is the LSB of the outgoing channel; it still
            // counts toward the slot length and may still carry data.
            cnt_d   = '0;
            shift_d = '0;
            if (cnt_inc == SLOT_C) begin
              cap_d         = bit_in ? shifted : shift_q;
              commit_d      = 1'b1;
              commit_chan_d = ws_prev_q;
              state_d       = ST_LOCKED;
            end else begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              state_d  = ST_ALIGN;
            end
          end else begin
            cnt_d = cnt_inc;
            if (bit_in) begin
              shift_d = shifted;
            end
            if (cnt_inc == SAT_C) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              state_d  = ST_SEEK;
            end
          end
        end
      endcase
    end
  end

  assign left_word  = left_q;
  assign right_word = right_q;
  assign word_valid = valid_q;
  assign word_chan  = chan_q;
  assign frame_err  = err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_clk, ws, sd;
  logic [23:0] left_word, right_word, left2, right2;
  logic        word_valid, word_chan, frame_err, locked;
  logic        wv2, wc2, fe2, lk2;

  i2s_receiver #(.NUM_BITS(24), .SLOT_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .word_select(ws), .serial_in(sd),
    .left_word(left_word), .right_word(right_word), .word_valid(word_valid),
    .word_chan(word_chan), .frame_err(frame_err), .locked(locked)
  );

  i2s_receiver #(.NUM_BITS(24), .SLOT_BITS(24), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .word_select(ws), .serial_in(sd),
    .left_word(left2), .right_word(right2), .word_valid(wv2),
    .word_chan(wc2), .frame_err(fe2), .locked(lk2)
  );

  int   tests = 0, fails = 0;
  int   nvalid = 0, nerr = 0, both = 0;
  int   nvalid2 = 0, nerr2 = 0, both2 = 0;
  logic last_chan = 1'b0, last_chan2 = 1'b0;
  int   lat;
  bit   sel = 1'b0;
  int   nv0, ne0;

  always @(negedge clk) begin
    if (word_valid) begin nvalid++; last_chan = word_chan; end
    if (frame_err) nerr++;
    if (word_valid && frame_err) both++;
    if (wv2) begin nvalid2++; last_chan2 = wc2; end
    if (fe2) nerr2++;
    if (wv2 && fe2) both2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit: data/WS change with s_clk low, then rising edge; lat records the
  // first negedge (1..4) after the rise at which the selected DUT's strobe is high.
  task automatic send_bit(input logic w, input logic d);
    s_clk = 1'b0; ws = w; sd = d;
    repeat (4) @(negedge clk);
    s_clk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if ((sel ? wv2 : word_valid) && lat == 0) lat = k;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic send_slot(input logic ch, input logic [23:0] data, input int len);
    for (int i = 0; i < len; i++) begin
      send_bit((i == len - 1) ? ~ch : ch, (i < 24) ? data[23 - i] : 1'b0);
    end
    settle();
  endtask

  initial begin
    rst = 1'b0; s_clk = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left", {8'h0, left_word}, 32'h0);
    check("rst_right", {8'h0, right_word}, 32'h0);
    check("rst_flags", {28'h0, word_valid, word_chan, frame_err, locked}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Partial slot then one full right slot before the first word.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    settle();
    check("partial_novalid", nvalid, 0);
    check("partial_unlocked", {31'h0, locked}, 32'h0);
    send_slot(1'b1, 24'h5A5A5A, 32);
    check("first_count", nvalid, 1);
    check("first_chan", {31'h0, last_chan}, 32'h1);
    check("first_right", {8'h0, right_word}, 32'h5A5A5A);
    check("first_locked", {31'h0, locked}, 32'h1);
    check("first_lat", lat, 4);

    // Nominal stereo
    send_slot(1'b0, 24'hABCDEF, 32);
    check("nom_left", {8'h0, left_word}, 32'hABCDEF);
    check("nom_lchan", {31'h0, last_chan}, 32'h0);
    check("nom_llat", lat, 4);
    send_slot(1'b1, 24'h123456, 32);
    check("nom_right", {8'h0, right_word}, 32'h123456);
    check("nom_rchan", {31'h0, last_chan}, 32'h1);
    check("nom_lhold", {8'h0, left_word}, 32'hABCDEF);
    check("nom_count", nvalid, 3);
    check("nom_noerr", nerr, 0);

    // Short left slot (20 bits)
    send_slot(1'b0, 24'h111111, 20);
    check("short_err", nerr, 1);
    check("short_novalid", nvalid, 3);
    check("short_unlocked", {31'h0, locked}, 32'h0);
    check("short_lhold", {8'h0, left_word}, 32'hABCDEF);
    send_slot(1'b1, 24'h654321, 32);
    check("short_rec_right", {8'h0, right_word}, 32'h654321);
    check("short_rec_locked", {31'h0, locked}, 32'h1);
    check("short_rec_count", nvalid, 4);
    send_slot(1'b0, 24'hFEDCBA, 32);
    check("short_rec_left", {8'h0, left_word}, 32'hFEDCBA);

    // Stuck WS for 40 bits
    for (int i = 0; i < 40; i++) send_bit(1'b1, 1'b1);
    settle();
    check("stuck_err", nerr, 2);
    check("stuck_unlocked", {31'h0, locked}, 32'h0);
    check("stuck_novalid", nvalid, 5);
    send_bit(1'b0, 1'b0);
    send_slot(1'b0, 24'h0F0F0F, 32);
    check("stuck_rec_left", {8'h0, left_word}, 32'h0F0F0F);
    check("stuck_rec_locked", {31'h0, locked}, 32'h1);
    check("stuck_rec_err", nerr, 2);

    // Reset mid-slot
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_left", {8'h0, left_word}, 32'h0);
    check("mid_rst_right", {8'h0, right_word}, 32'h0);
    check("mid_rst_flags", {28'h0, word_valid, word_chan, frame_err, locked}, 32'h0);
    s_clk = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nv0 = nvalid; ne0 = nerr;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    settle();
    check("mid_rst_nostale", nvalid - nv0, 0);
    send_slot(1'b1, 24'hC0FFEE, 32);
    check("mid_rst_first", nvalid - nv0, 1);
    check("mid_rst_right2", {8'h0, right_word}, 32'hC0FFEE);
    check("mid_rst_lzero", {8'h0, left_word}, 32'h0);

    // Ramp stream, alternating left/right
    for (int v = 1; v <= 16; v++) begin
      send_slot(v[0] ? 1'b0 : 1'b1, 24'(v), 32);
      check("ramp_word", {8'h0, (v[0] ? left_word : right_word)}, 32'(v));
      check("ramp_lat", lat, 4);
    end
    check("ramp_count", nvalid - nv0, 17);
    check("ramp_noerr", nerr - ne0, 0);

    // 24-bit slot instance: extremes and latency
    sel = 1'b1;
    rst = 1'b0; s_clk = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ne0 = nerr2;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    settle();
    check("ext_novalid", nvalid2, 0);
    send_slot(1'b1, 24'h7FFFFF, 24);
    check("ext_right", {8'h0, right2}, 32'h7FFFFF);
    check("ext_rchan", {31'h0, last_chan2}, 32'h1);
    check("ext_rlat", lat, 4);
    send_slot(1'b0, 24'h800000, 24);
    check("ext_left", {8'h0, left2}, 32'h800000);
    check("ext_lchan", {31'h0, last_chan2}, 32'h0);
    check("ext_llat", lat, 4);
    check("ext_rhold", {8'h0, right2}, 32'h7FFFFF);
    check("ext_locked", {31'h0, lk2}, 32'h1);
    check("ext_noerr", nerr2 - ne0, 0);

    check("never_both", both, 0);
    check("never_both24", both2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
